count_sequencer: RTL and testbench

//  Sequencing controller for a WIDTH-bit event counter: loads a start value, counts qualified

---
 rtl/count_sequencer.sv | 88 ++++++++
 tb/tb_count_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Start/stop/done sequencer around a WIDTH-bit up/down event counter.
// A run loads a start value, counts rising edges of event_in, and ends when the count reaches the terminal value.
module count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_up,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             event_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           cur;
  logic             ev_d;
  logic             step;
  logic             mode_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] load_reg;
  logic [WIDTH-1:0] term_reg;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    step      = event_in & ~ev_d;
    q_step    = mode_reg ? (q + WIDTH'(1)) : (q - WIDTH'(1));
    wrap_next = mode_reg ? (&q) : (q == '0);
  end

  // The terminal compare uses the stepped value only, so a run whose start equals its terminal needs a full lap.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur      <= IDLE;
      q        <= '0;
      wrap     <= 1'b0;
      mode_reg <= 1'b0;
      load_reg <= '0;
      term_reg <= '0;
      ev_d     <= 1'b0;
    end else begin
      ev_d <= event_in;
      wrap <= 1'b0;
      case (cur)
        IDLE: begin
          if (start) begin
            mode_reg <= mode_up;
            load_reg <= load_val;
            term_reg <= term_val;
            cur      <= LOAD;
          end
        end
        LOAD: begin
          q   <= load_reg;
          cur <= stop ? IDLE : RUN;
        end
        RUN: begin
          if (stop) begin
            cur <= IDLE;
          end else if (step) begin
            q    <= q_step;
            wrap <= wrap_next;
            if (q_step == term_reg) cur <= DONE;
          end
        end
        DONE:    cur <= IDLE;
        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;
  assign busy  = (cur == LOAD) || (cur == RUN);
  assign done  = (cur == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Scenario bench for count_sequencer: directed runs plus randomized runs against an arithmetic model of the count.
module tb_count_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode_up = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] term_val = 4'd0;
  logic       event_in = 1'b0;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       wrap;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  count_sequencer #(.WIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode_up(mode_up),
    .load_val(load_val), .term_val(term_val), .event_in(event_in),
    .q(q), .busy(busy), .done(done), .wrap(wrap), .state(state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: modulo-16 step and boundary crossing, from plain arithmetic.
  function automatic int model_next(input bit up, input int cur);
    return up ? (cur + 1) % 16 : (cur + 15) % 16;
  endfunction

  function automatic bit model_wrap(input bit up, input int cur);
    return up ? (cur == 15) : (cur == 0);
  endfunction

  function automatic int model_steps(input bit up, input int ld, input int tm);
    int n;
    n = up ? (tm - ld + 16) % 16 : (ld - tm + 16) % 16;
    return (n == 0) ? 16 : n;
  endfunction

  task automatic begin_run(input bit up, input logic [3:0] ld, input logic [3:0] tm);
    start = 1'b1; mode_up = up; load_val = ld; term_val = tm;
    tick();
    checks++;
    if (state !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL begin_run load_state: got state=%0d busy=%0b expected state=1 busy=1", state, busy);
    end
    start = 1'b0; load_val = 4'($urandom); term_val = 4'($urandom); mode_up = 1'($urandom);
    tick();
    checks++;
    if (state !== 2'd2 || q !== ld) begin
      failures++;
      $display("FAIL begin_run run_entry: got state=%0d q=%0d expected state=2 q=%0d", state, q, ld);
    end
  endtask

  // Pulses event_in until the modelled step count is reached, checking q/wrap/done after each step.
  task automatic run_pulses(input string name, input bit up, input int ld, input int tm, input bit gaps);
    int exp_q, n;
    bit exp_w;
    exp_q = ld;
    n = model_steps(up, ld, tm);
    for (int k = 1; k <= n; k++) begin
      exp_w = model_wrap(up, exp_q);
      exp_q = model_next(up, exp_q);
      event_in = 1'b1;
      tick();
      checks++;
      if (q !== 4'(exp_q) || wrap !== exp_w || done !== (k == n) || state !== ((k == n) ? 2'd3 : 2'd2)) begin
        failures++;
        $display("FAIL %s step%0d: got q=%0d wrap=%0b done=%0b state=%0d expected q=%0d wrap=%0b done=%0b",
                 name, k, q, wrap, done, state, exp_q, exp_w, (k == n));
      end
      event_in = 1'b0;
      tick();
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
    checks++;
    if (state !== 2'd0 || q !== 4'(tm) || done !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL %s end: got state=%0d q=%0d done=%0b wrap=%0b expected state=0 q=%0d done=0 wrap=0",
               name, state, q, done, wrap, tm);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 4'd0 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL test_reset: got q=%0d state=%0d busy=%0b done=%0b wrap=%0b expected all 0",
               q, state, busy, done, wrap);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_count_up();
    begin_run(1'b1, 4'd3, 4'd7);
    run_pulses("test_count_up", 1'b1, 3, 7, 1'b0);
  endtask

  task automatic test_count_down();
    begin_run(1'b0, 4'd1, 4'd14);
    run_pulses("test_count_down", 1'b0, 1, 14, 1'b0);
  endtask

  task automatic test_equal_terminal();
    begin_run(1'b1, 4'd5, 4'd5);
    run_pulses("test_equal_terminal", 1'b1, 5, 5, 1'b0);
  endtask

  task automatic test_stop();
    begin_run(1'b1, 4'd9, 4'd2);
    stop = 1'b1; event_in = 1'b1;
    tick();
    checks++;
    if (q !== 4'd9 || state !== 2'd0 || done !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL test_stop run_abort: got q=%0d state=%0d done=%0b wrap=%0b expected q=9 state=0",
               q, state, done, wrap);
    end
    stop = 1'b0; event_in = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL test_stop settle: got state=%0d done=%0b expected state=0 done=0", state, done);
    end
    start = 1'b1; load_val = 4'd11; term_val = 4'd0; mode_up = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== 2'd0 || q !== 4'd11) begin
      failures++;
      $display("FAIL test_stop load_abort: got state=%0d q=%0d expected state=0 q=11", state, q);
    end
  endtask

  task automatic test_level_hold();
    begin_run(1'b1, 4'd0, 4'd15);
    event_in = 1'b1;
    repeat (10) tick();
    checks++;
    if (q !== 4'd1 || state !== 2'd2) begin
      failures++;
      $display("FAIL test_level_hold: got q=%0d state=%0d expected q=1 state=2", q, state);
    end
    event_in = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_edges_outside_run();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tick();
    checks++;
    if (q !== 4'd1 || state !== 2'd0) begin
      failures++;
      $display("FAIL test_edges idle_edge: got q=%0d state=%0d expected q=1 state=0", q, state);
    end
    start = 1'b1; load_val = 4'd4; term_val = 4'd8; mode_up = 1'b1;
    tick();
    start = 1'b0; event_in = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 4'd4 || state !== 2'd2) begin
      failures++;
      $display("FAIL test_edges load_edge: got q=%0d state=%0d expected q=4 state=2", q, state);
    end
    event_in = 1'b0;
    tick();
    event_in = 1'b1;
    tick();
    checks++;
    if (q !== 4'd5) begin
      failures++;
      $display("FAIL test_edges first_run_edge: got q=%0d expected q=5", q);
    end
    event_in = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    begin_run(1'b1, 4'd3, 4'd12);
    repeat (3) begin
      event_in = 1'b1; tick();
      event_in = 1'b0; tick();
    end
    checks++;
    if (q !== 4'd6 || state !== 2'd2) begin
      failures++;
      $display("FAIL test_reset_mid_run pre: got q=%0d state=%0d expected q=6 state=2", q, state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (q !== 4'd0 || state !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL test_reset_mid_run post: got q=%0d state=%0d busy=%0b expected q=0 state=0 busy=0",
               q, state, busy);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    begin_run(1'b1, 4'd2, 4'd4);
    start = 1'b1; load_val = 4'd9; term_val = 4'd9; mode_up = 1'b0;
    tick();
    checks++;
    if (state !== 2'd2 || q !== 4'd2) begin
      failures++;
      $display("FAIL test_start_ignored run: got state=%0d q=%0d expected state=2 q=2", state, q);
    end
    start = 1'b0;
    event_in = 1'b1; tick();
    event_in = 1'b0; tick();
    event_in = 1'b1; tick();
    checks++;
    if (state !== 2'd3 || q !== 4'd4) begin
      failures++;
      $display("FAIL test_start_ignored reach_done: got state=%0d q=%0d expected state=3 q=4", state, q);
    end
    start = 1'b1; load_val = 4'd13; event_in = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 2'd0 || q !== 4'd4) begin
      failures++;
      $display("FAIL test_start_ignored in_done: got state=%0d q=%0d expected state=0 q=4", state, q);
    end
    tick();
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL test_start_ignored after_done: got state=%0d expected state=0", state);
    end
  endtask

  task automatic test_random();
    bit up;
    logic [3:0] ld, tm;
    for (int i = 0; i < 10; i++) begin
      up = 1'($urandom);
      ld = 4'($urandom);
      tm = 4'($urandom);
      begin_run(up, ld, tm);
      run_pulses("test_random", up, int'(ld), int'(tm), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_equal_terminal();
    test_stop();
    test_level_hold();
    test_edges_outside_run();
    test_reset_mid_run();
    test_start_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
